alu_muldiv_seq: RTL and testbench
=================================

Name: alu_muldiv_seq

Overview:
- Multi-cycle unsigned multiply/divide sequencer. It is the controlling end of the 4-bit-slice ALU interface: it drives function select, mode, carry-in and both operand buses, and consumes the function output and carry-out.
- The external ALU is a W-bit chain of 10181-style slices and is combinational, so each result is returned in the same cycle.
- Sits beside the main datapath ALU and takes start/result handshakes from the instruction sequencer.

Parameters:
- W, 36, operand width in bits; must be a multiple of 4.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; accepted when start && ready
- op_div  in  1  0 = multiply, 1 = divide; sampled at accept
- opa  in  W  multiplicand or dividend
- opb  in  W  multiplier or divisor
- ready  out  1  high only in IDLE
- res_valid  out  1  result available; held until res_ready
- res_ready  in  1  consumer accepts result
- res_hi  out  W  product high word, or remainder
- res_lo  out  W  product low word, or quotient
- res_dz  out  1  divide-by-zero flag
- alu_s  out  4  ALU function select
- alu_m  out  1  ALU mode (1 = logic)
- alu_cin  out  1  ALU carry-in
- alu_a  out  W  ALU A operand
- alu_b  out  W  ALU B operand
- alu_f  in  W  ALU result, same cycle
- alu_cout  in  1  ALU carry-out; for subtract, 1 = no borrow

Behaviour:
- Registers: AC[W], Q[W], MD[W], cnt[$clog2(W+1)], state.
- States: IDLE, MSTEP, DSTEP, DONE.
- Reset: state = IDLE, all registers 0, ready = 1, res_valid = 0, res_dz = 0, res_hi/lo = 0.
- IDLE:
  - ALU driven as pass-A: alu_s = 1111, alu_m = 1, alu_cin = 0, alu_a = alu_b = 0.
  - On accept: MD <= opb, cnt <= W.
  - Multiply: AC <= 0, Q <= opa, go to MSTEP.
  - Divide with opb == 0: AC <= opa, Q <= 0, res_dz <= 1, go to DONE. Result appears the next cycle.
  - Divide otherwise: AC <= 0, Q <= opa, go to DSTEP.
- MSTEP (add, alu_s = 0110, alu_m = 0, alu_cin = 0, alu_a = AC, alu_b = MD):
  - If Q[0] = 1: AC <= {alu_cout, alu_f[W-1:1]}, Q <= {alu_f[0], Q[W-1:1]}.
  - If Q[0] = 0: AC <= {0, AC[W-1:1]}, Q <= {AC[0], Q[W-1:1]}.
  - cnt--. When cnt == 1, go to DONE.
- DSTEP (subtract, alu_s = 1001, alu_m = 0, alu_cin = 1, alu_a = {AC[W-2:0], Q[W-1]}, alu_b = MD):
  - If AC[W-1] | alu_cout: AC <= alu_f, Q <= {Q[W-2:0], 1}.
  - Else: AC <= alu_a, Q <= {Q[W-2:0], 0}.
  - cnt--. When cnt == 1, go to DONE.
- DONE: res_valid = 1, res_hi = AC, res_lo = Q. On res_ready: go to IDLE and clear res_dz.
- Latency: accept in cycle 0, res_valid in cycle W+1 (DONE entered after exactly W steps). Divide-by-zero: cycle 1.
- Outputs res_hi/lo/dz are stable while res_valid is high and res_ready is low.
- start is ignored outside IDLE.
- If res_ready is already high on the first DONE cycle, DONE lasts one cycle.
- rst_n low at any point, including mid-step: immediately return to the reset state. The in-flight result is lost.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- When defined:
  - Add input op_signed (1 bit), sampled at accept.
  - Add states NEGA, NEGB before the step states and NEGH, NEGL after them. These four are always traversed for every operation, so latency is W+5.
  - Negation is performed through the ALU using alu_a = ~x, alu_s = 0000, alu_m = 0, with alu_cin = 1 for single words and the low word.
  - For the product high word, alu_cin = the low-word carry, captured in a flag.
  - Writeback happens only if op_signed and the relevant sign condition holds. Sign rules: product sign = a^b; quotient sign = a^b; remainder takes the sign of the dividend.
  - Signed divide-by-zero still takes the 1-cycle path.
- When undefined: no op_signed port, unsigned only, latency W+1.

Decomposition:
- Package alu_seq_pkg holds:
  - ALU code localparams: ALU_ADD = 4'b0110, ALU_SUB = 4'b1001, ALU_INC = 4'b0000, ALU_PASSA = 4'b1111.
  - The state enum typedef.
- No sub-module needed. The behavioural mc10181 chain is instantiated only in the bench to close the loop.

Test Plan:
- mul opa=3, opb=5 -> res_hi=0, res_lo=15; res_valid exactly in cycle 37.
- mul opa=opb=36'hFFFFFFFFF -> res_hi=36'hFFFFFFFFE, res_lo=1.
- div opa=100, opb=7 -> res_lo=14, res_hi=2, res_dz=0; also div 36'hFFFFFFFFF / 1 -> res_lo=all ones, res_hi=0.
- div opb=0, opa=55 -> res_dz=1, res_lo=0, res_hi=55, in cycle 1; res_dz clears after handshake.
- res_ready held low 10 cycles, start pulsed meanwhile -> outputs frozen, ready=0, second start ignored. Also rst_n low at step 10 -> ready=1, res_valid=0 next edge.
- With MULDIV_SIGNED_EN: -6 * 7 -> {res_hi,res_lo} = -42 (72-bit); -100 / 7 -> q=-14, r=-2, latency 41.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer.
//
// Contents:
//   - ALU function-select codes for the external 10181-style slice chain.
//   - The sequencer state enum.
package alu_seq_pkg;

    // Function-select codes. ALU_PASSA is used with logic mode; the rest use arithmetic mode.
    localparam logic [3:0] ALU_ADD   = 4'b0110;
    localparam logic [3:0] ALU_SUB   = 4'b1001;
    localparam logic [3:0] ALU_INC   = 4'b0000;
    localparam logic [3:0] ALU_PASSA = 4'b1111;

    // The negate states are only reachable when MULDIV_SIGNED_EN is defined.
    typedef enum logic [2:0] {
        StIdle,
        StMstep,
        StDstep,
        StDone,
        StNega,
        StNegb,
        StNegl,
        StNegh
    } state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer.
//
// It controls an external combinational W-bit ALU built from 10181-style slices. Multiply uses
// shift-and-add, and divide uses restoring division. Both take one ALU operation per step.
//
// Ports:
//   clk, rst_n             clock; asynchronous active-low reset
//   start, op_div          request (accepted when start && ready); 0 = multiply, 1 = divide
//   opa, opb               multiplicand/dividend, multiplier/divisor
//   ready                  high only while idle
//   res_valid, res_ready   result handshake; the result is held until res_ready
//   res_hi, res_lo, res_dz product high/low word, or remainder/quotient; divide-by-zero flag
//   alu_s, alu_m, alu_cin  ALU function select, mode (1 = logic), carry-in
//   alu_a, alu_b           ALU operands
//   alu_f, alu_cout        ALU result and carry-out (for subtract, 1 = no borrow)
//
// Build option: MULDIV_SIGNED_EN adds the op_signed input and four negate states (NEGA and NEGB
// before the steps, NEGL and NEGH after them). Signed latency is W+5, and unsigned latency is W+1.
// W must be a multiple of 4 so that the slice chain fits.
module alu_muldiv_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned W = 36
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         op_div,
`ifdef MULDIV_SIGNED_EN
    input  logic         op_signed,
`endif
    input  logic [W-1:0] opa,
    input  logic [W-1:0] opb,
    output logic         ready,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_hi,
    output logic [W-1:0] res_lo,
    output logic         res_dz,
    output logic [3:0]   alu_s,
    output logic         alu_m,
    output logic         alu_cin,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_f,
    input  logic         alu_cout
);

    localparam int unsigned CW = $clog2(W + 1);

    // When the step count runs out, the signed build still has to fix up the result signs.
`ifdef MULDIV_SIGNED_EN
    localparam state_e StAfterStep = StNegl;
`else
    localparam state_e StAfterStep = StDone;
`endif

    state_e         state_q, state_d;
    logic [W-1:0]   ac_q, ac_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   md_q, md_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           dz_q, dz_d;

`ifdef MULDIV_SIGNED_EN
    logic           sgn_q, sgn_d;
    logic           div_q, div_d;
    logic           a_neg_q, a_neg_d;
    logic           b_neg_q, b_neg_d;
    logic           c_q, c_d;       // low-word carry out of NEGL, used as the carry-in for NEGH
`endif

    // The partial remainder shifted left by one, taking in the next dividend bit.
    logic [W-1:0]   div_shift;
    assign div_shift = {ac_q[W-2:0], q_q[W-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ac_q    <= '0;
            q_q     <= '0;
            md_q    <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            sgn_q   <= 1'b0;
            div_q   <= 1'b0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            c_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ac_q    <= ac_d;
            q_q     <= q_d;
            md_q    <= md_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
`ifdef MULDIV_SIGNED_EN
            sgn_q   <= sgn_d;
            div_q   <= div_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            c_q     <= c_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ac_d    = ac_q;
        q_d     = q_q;
        md_d    = md_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
`ifdef MULDIV_SIGNED_EN
        sgn_d   = sgn_q;
        div_d   = div_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        c_d     = c_q;
`endif
        alu_s   = ALU_PASSA;
        alu_m   = 1'b1;
        alu_cin = 1'b0;
        alu_a   = '0;
        alu_b   = '0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    md_d  = opb;
                    cnt_d = CW'(W);
`ifdef MULDIV_SIGNED_EN
                    sgn_d   = op_signed;
                    div_d   = op_div;
                    a_neg_d = opa[W-1];
                    b_neg_d = opb[W-1];
`endif
                    if (op_div && (opb == '0)) begin
                        // Divide-by-zero returns the dividend as the remainder.
                        ac_d    = opa;
                        q_d     = '0;
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        ac_d = '0;
                        q_d  = opa;
`ifdef MULDIV_SIGNED_EN
                        state_d = StNega;
`else
                        state_d = op_div ? StDstep : StMstep;
`endif
                    end
                end
            end

            StMstep: begin
                alu_s = ALU_ADD;
                alu_m = 1'b0;
                alu_a = ac_q;
                alu_b = md_q;
                // {AC,Q} shifts right one bit, and the sum is kept only when the multiplier bit is 1.
                if (q_q[0]) begin
                    ac_d = {alu_cout, alu_f[W-1:1]};
                    q_d  = {alu_f[0], q_q[W-1:1]};
                end else begin
                    ac_d = {1'b0, ac_q[W-1:1]};
                    q_d  = {ac_q[0], q_q[W-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = StAfterStep;
                end
            end

            StDstep: begin
                alu_s   = ALU_SUB;
                alu_m   = 1'b0;
                alu_cin = 1'b1;
                alu_a   = div_shift;
                alu_b   = md_q;
                // If the bit shifted out of AC is set, the shifted value is already >= MD.
                if (ac_q[W-1] | alu_cout) begin
                    ac_d = alu_f;
                    q_d  = {q_q[W-2:0], 1'b1};
                end else begin
                    ac_d = div_shift;
                    q_d  = {q_q[W-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = StAfterStep;
                end
            end

            StDone: begin
                if (res_ready) begin
                    state_d = StIdle;
                    dz_d    = 1'b0;
                end
            end

`ifdef MULDIV_SIGNED_EN
            // Each negate state computes ~x + cin on the ALU. The result is written back only
            // when the sign rule calls for it.
            StNega: begin
                alu_s   = ALU_INC;
                alu_m   = 1'b0;
                alu_cin = 1'b1;
                alu_a   = ~q_q;
                if (sgn_q && a_neg_q) begin
                    q_d = alu_f;
                end
                state_d = StNegb;
            end

            StNegb: begin
                alu_s   = ALU_INC;
                alu_m   = 1'b0;
                alu_cin = 1'b1;
                alu_a   = ~md_q;
                if (sgn_q && b_neg_q) begin
                    md_d = alu_f;
                end
                state_d = div_q ? StDstep : StMstep;
            end

            StNegl: begin
                alu_s   = ALU_INC;
                alu_m   = 1'b0;
                alu_cin = 1'b1;
                alu_a   = ~q_q;
                c_d     = alu_cout;
                if (sgn_q && (a_neg_q ^ b_neg_q)) begin
                    q_d = alu_f;
                end
                state_d = StNegh;
            end

            StNegh: begin
                alu_s   = ALU_INC;
                alu_m   = 1'b0;
                alu_cin = div_q ? 1'b1 : c_q;
                alu_a   = ~ac_q;
                // A remainder takes the dividend's sign. A product high word takes the product's sign.
                if (sgn_q && (div_q ? a_neg_q : (a_neg_q ^ b_neg_q))) begin
                    ac_d = alu_f;
                end
                state_d = StDone;
            end
`endif

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ready     = (state_q == StIdle);
    assign res_valid = (state_q == StDone);
    assign res_hi    = res_valid ? ac_q : '0;
    assign res_lo    = res_valid ? q_q : '0;
    assign res_dz    = dz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq. It closes the loop with a behavioural ALU and checks
// directed vectors, handshake and reset corner cases, and random operations against an
// arithmetic model.
module tb_alu_muldiv_seq;

    localparam int unsigned W  = 36;
    localparam int unsigned DW = 2 * W;
`ifdef MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
    localparam int XLAT      = 4;
`else
    localparam bit SIGNED_EN = 1'b0;
    localparam int XLAT      = 0;
`endif
    localparam int OP_LAT = W + 1 + XLAT;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op_div;
    logic         op_signed;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         ready;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_hi;
    logic [W-1:0] res_lo;
    logic         res_dz;
    logic [3:0]   alu_s;
    logic         alu_m;
    logic         alu_cin;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [W-1:0] alu_f;
    logic         alu_cout;

    alu_muldiv_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_div    (op_div),
`ifdef MULDIV_SIGNED_EN
        .op_signed (op_signed),
`endif
        .opa       (opa),
        .opb       (opb),
        .ready     (ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_hi    (res_hi),
        .res_lo    (res_lo),
        .res_dz    (res_dz),
        .alu_s     (alu_s),
        .alu_m     (alu_m),
        .alu_cin   (alu_cin),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_cout  (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural slice chain, covering the functions the sequencer uses.
    logic [W:0] alu_res;
    always_comb begin
        alu_res = '0;
        if (alu_m) begin
            if (alu_s == 4'b1111) alu_res = {1'b0, alu_a};
        end else begin
            case (alu_s)
                4'b0110: alu_res = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_cin};
                4'b1001: alu_res = {1'b0, alu_a} + {1'b0, ~alu_b} + {{W{1'b0}}, alu_cin};
                4'b0000: alu_res = {1'b0, alu_a} + {{W{1'b0}}, alu_cin};
                default: alu_res = '0;
            endcase
        end
    end
    assign alu_f    = alu_res[W-1:0];
    assign alu_cout = alu_res[W];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Arithmetic reference model.
    function automatic void model(input bit div, input bit sgn, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] hi,
                                  output logic [W-1:0] lo, output logic dz);
        logic signed [DW-1:0] sa, sb, sq, sr;
        logic [DW-1:0]        ua, ub, uq, ur;
        sa = $signed({{W{a[W-1]}}, a});
        sb = $signed({{W{b[W-1]}}, b});
        ua = {{W{1'b0}}, a};
        ub = {{W{1'b0}}, b};
        dz = 1'b0;
        if (div && (b == '0)) begin
            hi = a;
            lo = '0;
            dz = 1'b1;
        end else if (sgn && SIGNED_EN) begin
            if (div) begin
                sq = sa / sb;
                sr = sa % sb;
                lo = sq[W-1:0];
                hi = sr[W-1:0];
            end else begin
                sq = sa * sb;
                {hi, lo} = sq;
            end
        end else begin
            if (div) begin
                uq = ua / ub;
                ur = ua % ub;
                lo = uq[W-1:0];
                hi = ur[W-1:0];
            end else begin
                uq = ua * ub;
                {hi, lo} = uq;
            end
        end
    endfunction

    // Runs one operation from a negedge and checks the result and its latency. On return the
    // bench is again at a negedge, with the handshake complete.
    task automatic apply(input string tag, input bit div, input bit sgn, input bit early,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                         input logic exp_dz, input int exp_lat);
        int n;
        int lat;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        op_div    = div;
        op_signed = sgn;
        opa       = a;
        opb       = b;
        res_ready = early;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!res_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, DW'(lat), DW'(exp_lat));
        check({tag, "_hi"}, DW'(res_hi), DW'(exp_hi));
        check({tag, "_lo"}, DW'(res_lo), DW'(exp_lo));
        check({tag, "_dz"}, DW'(res_dz), DW'(exp_dz));
        if (!early) res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check({tag, "_idle_after"}, DW'(ready), DW'(1));
        check({tag, "_dz_cleared"}, DW'(res_dz), DW'(0));
    endtask

    typedef struct {
        bit           div;
        bit           sgn;
        bit           early;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [W-1:0] mhi, mlo, ra, rb;
        logic         mdz;
        logic [63:0]  r64;
        bit           rdiv;
        int           n;

        vecs.push_back('{1'b0, 1'b0, 1'b0, W'(3), W'(5), W'(0), W'(15), 1'b0, OP_LAT});
        vecs.push_back('{1'b0, 1'b0, 1'b0, {W{1'b1}}, {W{1'b1}}, {{(W-1){1'b1}}, 1'b0},
                         W'(1), 1'b0, OP_LAT});
        vecs.push_back('{1'b1, 1'b0, 1'b0, W'(100), W'(7), W'(2), W'(14), 1'b0, OP_LAT});
        vecs.push_back('{1'b1, 1'b0, 1'b0, {W{1'b1}}, W'(1), W'(0), {W{1'b1}}, 1'b0, OP_LAT});
        vecs.push_back('{1'b1, 1'b0, 1'b0, W'(55), W'(0), W'(55), W'(0), 1'b1, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b0, W'(5), W'(9), W'(5), W'(0), 1'b0, OP_LAT});
        vecs.push_back('{1'b0, 1'b0, 1'b1, W'(0), W'(12345), W'(0), W'(0), 1'b0, OP_LAT});
        vecs.push_back('{1'b1, 1'b0, 1'b1, W'(1000), W'(10), W'(0), W'(100), 1'b0, OP_LAT});
`ifdef MULDIV_SIGNED_EN
        vecs.push_back('{1'b0, 1'b1, 1'b0, W'(-6), W'(7), {W{1'b1}}, W'(-42), 1'b0, W + 5});
        vecs.push_back('{1'b1, 1'b1, 1'b0, W'(-100), W'(7), W'(-2), W'(-14), 1'b0, 41});
        vecs.push_back('{1'b1, 1'b1, 1'b0, W'(-9), W'(0), W'(-9), W'(0), 1'b1, 1});
`endif

        rst_n     = 1'b0;
        start     = 1'b0;
        op_div    = 1'b0;
        op_signed = 1'b0;
        opa       = '0;
        opb       = '0;
        res_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ready", DW'(ready), DW'(1));
        check("rst_valid", DW'(res_valid), DW'(0));
        check("rst_dz", DW'(res_dz), DW'(0));
        check("rst_hi", DW'(res_hi), DW'(0));
        check("rst_lo", DW'(res_lo), DW'(0));
        check("rst_alu_s", DW'(alu_s), DW'(4'b1111));
        check("rst_alu_m", DW'(alu_m), DW'(1));
        check("rst_alu_ab", DW'({alu_a, alu_b}), DW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            apply($sformatf("vec%0d", i), vecs[i].div, vecs[i].sgn, vecs[i].early, vecs[i].a,
                  vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz, vecs[i].lat);
        end

        // Stall: the result stays frozen while res_ready is low, and start is ignored meanwhile.
        op_div    = 1'b0;
        op_signed = 1'b0;
        opa       = W'(3);
        opb       = W'(5);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n     = 1;
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stall_lat", DW'(n), DW'(OP_LAT));
        for (int i = 0; i < 10; i++) begin
            check("stall_hi", DW'(res_hi), DW'(0));
            check("stall_lo", DW'(res_lo), DW'(15));
            check("stall_valid_ready", DW'({res_valid, ready, res_dz}), DW'(3'b100));
            if (i == 3) begin
                start  = 1'b1;
                op_div = 1'b1;
                opa    = W'(77);
                opb    = W'(0);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start     = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("stall_release_ready", DW'(ready), DW'(1));
        repeat (2) @(negedge clk);
        check("stall_start_ignored", DW'({ready, res_valid}), DW'(2'b10));

        // Reset asserted mid-operation.
        op_div = 1'b0;
        opa    = W'(9);
        opb    = W'(11);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst_busy", DW'(ready), DW'(0));
        rst_n = 1'b0;
        #1;
        check("midrst_async", DW'({ready, res_valid}), DW'(2'b10));
        @(posedge clk);
        #1;
        check("midrst_edge", DW'({ready, res_valid, res_dz}), DW'(3'b100));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            rdiv = 1'($urandom_range(0, 1));
            op_signed = SIGNED_EN & 1'($urandom_range(0, 1));
            r64 = {$urandom(), $urandom()};
            ra  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : r64[W-1:0];
            r64 = {$urandom(), $urandom()};
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1, 2:    rb = W'($urandom_range(1, 300));
                default: rb = r64[W-1:0];
            endcase
            model(rdiv, op_signed, ra, rb, mhi, mlo, mdz);
            apply($sformatf("rnd%0d", i), rdiv, op_signed, 1'($urandom_range(0, 1)), ra, rb,
                  mhi, mlo, mdz, mdz ? 1 : OP_LAT);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
